encode_n_seq: RTL and testbench

- Sequential multi-hot encoder, N-bit index space.
- Accepts an M-bit request vector over a valid/ready handshake.
- Emits the binary index of every set bit, one index per output handshake, with last and remaining-count sideband.
- Successor to the combinational one-hot encoder. Used where several requests can be asserted at once and each must be serviced individually, for example interrupt or event draining.

---
 rtl/encode_n_seq.sv | 123 ++++++++++++
 tb/tb_encode_n_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/encode_n_seq.sv
// Sequential multi-hot encoder: accepts an M-bit request vector and emits the index of
// each set bit, one per output handshake. Define ENCODE_MSB_FIRST_EN to scan highest bit first.
module encode_n_seq #(
  parameter int N = 4,
  parameter int M = 1 << N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         out_last,
  output logic [N:0]   out_rem,
  output logic         zero_in
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [N:0] REM_ONE = (N+1)'(1);

  state_t       state_reg, state_next;
  logic [M-1:0] pend_reg, pend_next;
  logic [N:0]   rem_reg, rem_next;
  logic         zero_reg, zero_next;

  logic [M-1:0] scan_vec;
  logic [M-1:0] clr_mask;
  logic [N-1:0] scan_idx;
  logic [N-1:0] y_raw;
  logic [N:0]   pop_cnt;
  logic         busy;

  // The MSB-first build simply mirrors the pending vector so one lowest-bit finder serves both.
  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_scan
`ifdef ENCODE_MSB_FIRST_EN
      assign scan_vec[gi] = pend_reg[M-1-gi];
`else
      assign scan_vec[gi] = pend_reg[gi];
`endif
    end
  endgenerate

  always_comb begin
    scan_idx = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (scan_vec[i]) scan_idx = N'(i);
    end
  end

`ifdef ENCODE_MSB_FIRST_EN
  assign y_raw = ~scan_idx;
`else
  assign y_raw = scan_idx;
`endif

  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_clr
      assign clr_mask[gi] = (y_raw == N'(gi));
    end
  endgenerate

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < M; i++) begin
      pop_cnt = pop_cnt + {{N{1'b0}}, in[i]};
    end
  end

  assign busy      = (state_reg == BUSY);
  assign in_ready  = rst_n && (state_reg == IDLE);
  assign out_valid = busy;
  assign y         = busy ? y_raw : '0;
  assign out_last  = busy && (rem_reg == REM_ONE);
  assign out_rem   = busy ? rem_reg : '0;
  assign zero_in   = zero_reg;

  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    rem_next   = rem_reg;
    zero_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (in == '0) begin
            zero_next = 1'b1;
          end else begin
            pend_next  = in;
            rem_next   = pop_cnt;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (out_ready) begin
          pend_next = pend_reg & ~clr_mask;
          rem_next  = rem_reg - REM_ONE;
          if (rem_reg == REM_ONE) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
      rem_reg   <= '0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      rem_reg   <= rem_next;
      zero_reg  <= zero_next;
    end
  end

endmodule

// File: tb/tb_encode_n_seq.sv
// Directed bench for encode_n_seq: expected indices are queued at vector accept and
// compared as each output handshake is observed.
module tb_encode_n_seq;

  localparam int N = 4;
  localparam int M = 16;

  typedef struct {
    logic [N-1:0] y;
    logic         last;
    logic [N:0]   rem;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [M-1:0] in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] y;
  logic         out_last;
  logic [N:0]   out_rem;
  logic         zero_in;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  encode_n_seq #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_last(out_last),
    .out_rem(out_rem), .zero_in(zero_in)
  );

  `define CHK(tag, obs, exp) begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
    end \
  end

  function automatic void push_expected(input logic [M-1:0] v);
    int p = 0;
    int k = 0;
    exp_t e;
    for (int i = 0; i < M; i++) if (v[i]) p++;
`ifdef ENCODE_MSB_FIRST_EN
    for (int i = M - 1; i >= 0; i--) begin
`else
    for (int i = 0; i < M; i++) begin
`endif
      if (v[i]) begin
        e.y    = N'(i);
        e.rem  = (N+1)'(p - k);
        e.last = (k == p - 1);
        sb.push_back(e);
        k++;
      end
    end
  endfunction

  // Called just after a falling edge; returns just after the accepting rising edge.
  task automatic send_vec(input logic [M-1:0] v);
    int n = 0;
    in = v;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout: in_ready never rose for vector %h", v);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in = M'($urandom);
    if (v != '0) push_expected(v);
    $display("accept in=%h", v);
  endtask

  task automatic drain(input int stall, input int max_pops);
    int cyc = 0;
    int stalled = 0;
    int pops = 0;
    @(negedge clk);
    while (sb.size() > 0 && pops < max_pops && cyc < 200) begin
      `CHK("out_valid_busy", out_valid, 1'b1)
      `CHK("in_ready_busy", in_ready, 1'b0)
      `CHK("y", y, sb[0].y)
      `CHK("out_last", out_last, sb[0].last)
      `CHK("out_rem", out_rem, sb[0].rem)
      $display("out y=%0d last=%0b rem=%0d ready=%0b", y, out_last, out_rem, stalled >= stall);
      if (stalled >= stall) begin
        out_ready = 1'b1;
        void'(sb.pop_front());
        pops++;
      end else begin
        out_ready = 1'b0;
        stalled++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left", sb.size());
    end
    if (sb.size() == 0) begin
      `CHK("idle_out_valid", out_valid, 1'b0)
      `CHK("idle_in_ready", in_ready, 1'b1)
      `CHK("idle_y", y, 4'h0)
      `CHK("idle_rem", out_rem, 5'h00)
      `CHK("idle_last", out_last, 1'b0)
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    `CHK("rst_in_ready", in_ready, 1'b0)
    `CHK("rst_out_valid", out_valid, 1'b0)
    `CHK("rst_y", y, 4'h0)
    `CHK("rst_rem", out_rem, 5'h00)
    `CHK("rst_last", out_last, 1'b0)
    `CHK("rst_zero_in", zero_in, 1'b0)
    rst_n = 1'b1;
    @(negedge clk);
    `CHK("post_rst_in_ready", in_ready, 1'b1)

    // Single bits from 15 down to 0
    for (int b = M - 1; b >= 0; b--) begin
      logic [M-1:0] v;
      v = '0;
      v[b] = 1'b1;
      send_vec(v);
      drain(0, 100);
    end

    send_vec(16'hA005);
    drain(0, 100);

    send_vec(16'h0011);
    drain(3, 100);

    // Zero vector: one-cycle zero_in pulse, nothing emitted
    send_vec(16'h0000);
    @(negedge clk);
    `CHK("zero_pulse", zero_in, 1'b1)
    `CHK("zero_out_valid", out_valid, 1'b0)
    `CHK("zero_in_ready", in_ready, 1'b1)
    @(negedge clk);
    `CHK("zero_pulse_end", zero_in, 1'b0)
    `CHK("zero_out_valid2", out_valid, 1'b0)

    send_vec(16'hFFFF);
    drain(0, 100);

    // Reset in the middle of a vector
    send_vec(16'h00F0);
    drain(0, 2);
    rst_n = 1'b0;
    @(negedge clk);
    `CHK("midrst_out_valid", out_valid, 1'b0)
    `CHK("midrst_y", y, 4'h0)
    `CHK("midrst_rem", out_rem, 5'h00)
    `CHK("midrst_last", out_last, 1'b0)
    `CHK("midrst_in_ready", in_ready, 1'b0)
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk);
    `CHK("midrst_idle", in_ready, 1'b1)
    `CHK("midrst_no_output", out_valid, 1'b0)
    send_vec(16'h0002);
    drain(0, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
